// File: rtl/beeb_1mhz_bus_master_pkg.sv
// beeb_1mhz_pkg: shared constants and FSM state type for the 1MHz bus master.
package beeb_1mhz_pkg;
    localparam logic [7:0] FC_PAGE_HI = 8'hFF;
    localparam logic [7:0] FC_PAGE_MID = 8'hFE;
    localparam logic [4:0] JIM_SEL_DEFAULT = 5'b11001;
    typedef enum logic [1:0] {IDLE, PG_HI, PG_MID, ACCESS} bm_state_t;
endpackage

// File: rtl/beeb_1mhz_bus_master_if.sv
// beeb_1mhz_bus_master_if: command/response handshake plus 1MHz bus pins.
interface beeb_1mhz_bus_master_if;
    logic cmd_valid, cmd_ready, cmd_jim, cmd_page, cmd_rnw;
    logic [18:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic rsp_valid;
    logic [7:0] rsp_rdata;
    logic clke, rnw, pgfc_n, pgfd_n, bus_data_oe;
    logic [7:0] bus_addr, bus_data_o, bus_data_i;
    modport master (
        input cmd_valid, cmd_jim, cmd_page, cmd_rnw, cmd_addr, cmd_wdata, bus_data_i,
        output cmd_ready, rsp_valid, rsp_rdata, clke, rnw, pgfc_n, pgfd_n, bus_addr,
        output bus_data_o, bus_data_oe
    );
    modport slave (
        output cmd_valid, cmd_jim, cmd_page, cmd_rnw, cmd_addr, cmd_wdata, bus_data_i,
        input cmd_ready, rsp_valid, rsp_rdata, clke, rnw, pgfc_n, pgfd_n, bus_addr,
        input bus_data_o, bus_data_oe
    );
endinterface

// File: rtl/beeb_1mhz_bus_master_phase_gen.sv
// beeb_1mhz_phase_gen: free-running bus-cycle phase counter, clke and phase strobes.
module beeb_1mhz_phase_gen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk50,
    input  logic rst,
    output logic clke,
    output logic cyc_start,
    output logic data_phase,
    output logic sample,
    output logic cyc_end
);
    localparam int PW = $clog2(CLK_DIV);
    logic [PW-1:0] ph_q, ph_d;
    always_comb ph_d = cyc_end ? '0 : ph_q + PW'(1);
    always_ff @(posedge clk50) ph_q <= rst ? '0 : ph_d;
    assign cyc_start = ph_q == '0;
    assign data_phase = ph_q >= PW'(CLK_DIV / 2);
    assign sample = ph_q == PW'(CLK_DIV - 2);
    assign cyc_end = ph_q == PW'(CLK_DIV - 1);
    assign clke = data_phase;
endmodule

// File: rtl/beeb_1mhz_bus_master.sv
// beeb_1mhz_bus_master: drives FRED/JIM accesses on the BBC Micro 1MHz bus,
// caching the JIM paging registers so only changed ones are rewritten.
module beeb_1mhz_bus_master
    import beeb_1mhz_pkg::*;
#(
    parameter int CLK_DIV = 50,
    parameter logic [4:0] JIM_SEL = JIM_SEL_DEFAULT
) (
    input logic clk50,
    input logic rst,
    beeb_1mhz_bus_master_if.master bus
);
    logic cyc_start, data_phase, sample, cyc_end;
    bm_state_t state_q, state_d;
    logic pend_q, pend_d, jim_q, jim_d, page_q, page_d, crnw_q, crnw_d;
    logic [18:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic hi_valid_q, hi_valid_d, mid_valid_q, mid_valid_d;
    logic [2:0] hi_cache_q, hi_cache_d;
    logic [7:0] mid_cache_q, mid_cache_d;
    logic rnw_q, rnw_d, pgfc_n_q, pgfc_n_d, pgfd_n_q, pgfd_n_d, rsp_valid_q, rsp_valid_d;
    logic [7:0] bus_addr_q, bus_addr_d, bus_data_o_q, bus_data_o_d, rsp_rdata_q, rsp_rdata_d;
    logic ready, accept, hi_miss, mid_miss;

    beeb_1mhz_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
        .clk50(clk50), .rst(rst), .clke(bus.clke), .cyc_start(cyc_start),
        .data_phase(data_phase), .sample(sample), .cyc_end(cyc_end)
    );

    // pend_q holds an accepted command until the next bus-cycle boundary
    assign ready = state_q == IDLE && !pend_q && !rst;
    assign accept = bus.cmd_valid && ready;
    assign hi_miss = !hi_valid_q || addr_q[18:16] != hi_cache_q;
    assign mid_miss = !mid_valid_q || addr_q[15:8] != mid_cache_q;

    always_comb begin
        state_d = state_q;
        pend_d = pend_q;
        jim_d = jim_q;
        page_d = page_q;
        crnw_d = crnw_q;
        addr_d = addr_q;
        wdata_d = wdata_q;
        hi_valid_d = hi_valid_q;
        mid_valid_d = mid_valid_q;
        hi_cache_d = hi_cache_q;
        mid_cache_d = mid_cache_q;
        rnw_d = rnw_q;
        pgfc_n_d = pgfc_n_q;
        pgfd_n_d = pgfd_n_q;
        bus_addr_d = bus_addr_q;
        bus_data_o_d = bus_data_o_q;
        if (accept) begin
            pend_d = 1'b1;
            jim_d = bus.cmd_jim;
            page_d = bus.cmd_page;
            crnw_d = bus.cmd_rnw;
            addr_d = bus.cmd_addr;
            wdata_d = bus.cmd_wdata;
            // a raw write to either paging register makes the cache untrustworthy
            if (!bus.cmd_jim && !bus.cmd_page && !bus.cmd_rnw && bus.cmd_addr[7:1] == 7'h7F) begin
                hi_valid_d = 1'b0;
                mid_valid_d = 1'b0;
            end
        end
        if (cyc_end) begin
            case (state_q)
                IDLE: if (pend_q) begin
                    pend_d = 1'b0;
                    state_d = !jim_q ? ACCESS : hi_miss ? PG_HI : mid_miss ? PG_MID : ACCESS;
                end
                PG_HI: begin
                    hi_valid_d = 1'b1;
                    hi_cache_d = addr_q[18:16];
                    state_d = mid_miss ? PG_MID : ACCESS;
                end
                PG_MID: begin
                    mid_valid_d = 1'b1;
                    mid_cache_d = addr_q[15:8];
                    state_d = ACCESS;
                end
                default: state_d = IDLE;
            endcase
            pgfc_n_d = !(state_d == PG_HI || state_d == PG_MID || (state_d == ACCESS && !jim_q && !page_q));
            pgfd_n_d = !(state_d == ACCESS && (jim_q || page_q));
            rnw_d = state_d == ACCESS ? crnw_q : state_d == IDLE;
            bus_addr_d = state_d == PG_HI ? FC_PAGE_HI : state_d == PG_MID ? FC_PAGE_MID :
                         state_d == ACCESS ? addr_q[7:0] : bus_addr_q;
            bus_data_o_d = state_d == PG_HI ? {JIM_SEL, addr_q[18:16]} : state_d == PG_MID ? addr_q[15:8] :
                           state_d == ACCESS && !crnw_q ? wdata_q : bus_data_o_q;
        end
        rsp_valid_d = state_q == ACCESS && sample;
        rsp_rdata_d = state_q == ACCESS && cyc_start && !crnw_q ? 8'h00 :
                      state_q == ACCESS && sample && crnw_q ? bus.bus_data_i : rsp_rdata_q;
    end

    always_ff @(posedge clk50) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q <= 1'b0;
            jim_q <= 1'b0;
            page_q <= 1'b0;
            crnw_q <= 1'b1;
            addr_q <= '0;
            wdata_q <= '0;
            hi_valid_q <= 1'b0;
            mid_valid_q <= 1'b0;
            hi_cache_q <= '0;
            mid_cache_q <= '0;
            rnw_q <= 1'b1;
            pgfc_n_q <= 1'b1;
            pgfd_n_q <= 1'b1;
            bus_addr_q <= '0;
            bus_data_o_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q <= pend_d;
            jim_q <= jim_d;
            page_q <= page_d;
            crnw_q <= crnw_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            hi_valid_q <= hi_valid_d;
            mid_valid_q <= mid_valid_d;
            hi_cache_q <= hi_cache_d;
            mid_cache_q <= mid_cache_d;
            rnw_q <= rnw_d;
            pgfc_n_q <= pgfc_n_d;
            pgfd_n_q <= pgfd_n_d;
            bus_addr_q <= bus_addr_d;
            bus_data_o_q <= bus_data_o_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.cmd_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rnw = rnw_q;
    assign bus.pgfc_n = pgfc_n_q;
    assign bus.pgfd_n = pgfd_n_q;
    assign bus.bus_addr = bus_addr_q;
    assign bus.bus_data_o = bus_data_o_q;
    // write data is only driven while clke is high
    assign bus.bus_data_oe = data_phase && !rnw_q;
endmodule

// File: tb/tb_beeb_1mhz_bus_master.sv
// tb_beeb_1mhz_bus_master: directed commands with a queued scoreboard of
// expected bus cycles and responses checked by a negedge monitor.
module tb_beeb_1mhz_bus_master;
    localparam int DIV = 50;
    localparam int HALF = DIV / 2;
    typedef struct packed {
        logic fc_n, fd_n, rnw;
        logic [7:0] addr, data;
    } cyc_t;

    logic clk50 = 1'b0, rst = 1'b1, rst_seen = 1'b1, clke_prev = 1'b0;
    logic active = 1'b0, ready_chk = 1'b0;
    int tick = 0, total = 0, bad = 0;
    cyc_t exp_cyc[$];
    logic [7:0] exp_rsp[$];
    cyc_t cur, e;

    beeb_1mhz_bus_master_if bif ();
    beeb_1mhz_bus_master #(.CLK_DIV(DIV), .JIM_SEL(5'b11001)) dut (.clk50(clk50), .rst(rst), .bus(bif));

    always #10 clk50 = ~clk50;
    always @(posedge clk50) rst_seen <= rst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk50) begin
        tick = (rst_seen || (clke_prev && !bif.clke)) ? 0 : tick + 1;
        clke_prev = bif.clke;
        if (rst_seen) active = 1'b0;
        if (tick == 0) begin
            active = !bif.pgfc_n || !bif.pgfd_n;
            cur = '{bif.pgfc_n, bif.pgfd_n, bif.rnw, bif.bus_addr, bif.bus_data_o};
            if (active && exp_cyc.size() == 0) chk("cyc_unexpected", 1, 0);
            else if (active) begin
                e = exp_cyc.pop_front();
                chk("cyc_pgfc_n", bif.pgfc_n, e.fc_n);
                chk("cyc_pgfd_n", bif.pgfd_n, e.fd_n);
                chk("cyc_rnw", bif.rnw, e.rnw);
                chk("cyc_addr", bif.bus_addr, e.addr);
                if (!e.rnw) chk("cyc_wdata", bif.bus_data_o, e.data);
            end else chk("idle_rnw", bif.rnw, 1);
        end
        if (active && tick == HALF - 1) chk("oe_low_phase", bif.bus_data_oe, 0);
        if (active && tick == HALF) chk("oe_high_phase", bif.bus_data_oe, !cur.rnw);
        if (active && tick == DIV - 1)
            chk("cyc_hold", {bif.pgfc_n, bif.pgfd_n, bif.rnw, bif.bus_addr, bif.bus_data_o, bif.bus_data_oe},
                {cur.fc_n, cur.fd_n, cur.rnw, cur.addr, cur.data, !cur.rnw});
        if (ready_chk) chk("ready_after_rsp", bif.cmd_ready, 1);
        ready_chk = 1'b0;
        if (bif.rsp_valid) begin
            chk("rsp_phase", tick, DIV - 1);
            if (exp_rsp.size() == 0) chk("rsp_unexpected", 1, 0);
            else chk("rsp_rdata", bif.rsp_rdata, exp_rsp.pop_front());
            ready_chk = 1'b1;
        end
    end

    task automatic push(input logic fc_n, input logic fd_n, input logic rnw, input logic [7:0] addr,
                        input logic [7:0] data);
        exp_cyc.push_back('{fc_n, fd_n, rnw, addr, data});
    endtask

    task automatic issue(input logic jim, input logic page, input logic rnw, input logic [18:0] addr,
                         input logic [7:0] wd);
        int n = 0;
        while (!bif.cmd_ready && n < 400) begin
            @(negedge clk50);
            #1;
            n++;
        end
        chk("cmd_ready_wait", bif.cmd_ready, 1);
        bif.cmd_jim = jim;
        bif.cmd_page = page;
        bif.cmd_rnw = rnw;
        bif.cmd_addr = addr;
        bif.cmd_wdata = wd;
        bif.cmd_valid = 1'b1;
        @(posedge clk50);
        #1;
        bif.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_cyc.size() != 0 || exp_rsp.size() != 0 || !bif.cmd_ready) && n < 1000) begin
            @(negedge clk50);
            #1;
            n++;
        end
        chk("drain", exp_cyc.size() + exp_rsp.size(), 0);
    endtask

    initial begin
        bif.cmd_valid = 1'b0;
        bif.cmd_jim = 1'b0;
        bif.cmd_page = 1'b0;
        bif.cmd_rnw = 1'b1;
        bif.cmd_addr = '0;
        bif.cmd_wdata = '0;
        bif.bus_data_i = 8'h3C;
        repeat (3) @(negedge clk50);
        #1;
        chk("rst_clke", bif.clke, 0);
        chk("rst_pgfc_n", bif.pgfc_n, 1);
        chk("rst_pgfd_n", bif.pgfd_n, 1);
        chk("rst_rnw", bif.rnw, 1);
        chk("rst_addr", bif.bus_addr, 0);
        chk("rst_data_o", bif.bus_data_o, 0);
        chk("rst_oe", bif.bus_data_oe, 0);
        chk("rst_rsp", {bif.rsp_valid, bif.rsp_rdata}, 0);
        chk("rst_ready", bif.cmd_ready, 0);
        rst = 1'b0;
        // raw FC write
        push(0, 1, 0, 8'hA0, 8'h80); exp_rsp.push_back(8'h00);
        issue(0, 0, 0, 19'h000A0, 8'h80);
        drain();
        // JIM write from cold cache: both paging writes
        push(0, 1, 0, 8'hFF, 8'hC9); push(0, 1, 0, 8'hFE, 8'h23); push(1, 0, 0, 8'h45, 8'h5A);
        exp_rsp.push_back(8'h00);
        issue(1, 0, 0, 19'h12345, 8'h5A);
        // cache hit
        push(1, 0, 1, 8'h46, 8'h00); exp_rsp.push_back(8'h3C);
        issue(1, 0, 1, 19'h12346, 8'h00);
        drain();
        bif.bus_data_i = 8'h77;
        // only the high page changes
        push(0, 1, 0, 8'hFF, 8'hCA); push(1, 0, 1, 8'h46, 8'h00); exp_rsp.push_back(8'h77);
        issue(1, 0, 1, 19'h22346, 8'h00);
        drain();
        bif.bus_data_i = 8'hA5;
        push(1, 0, 1, 8'h10, 8'h00); exp_rsp.push_back(8'hA5);
        issue(0, 1, 1, 19'h00010, 8'h00);
        push(0, 1, 1, 8'hFF, 8'h00); exp_rsp.push_back(8'hA5);
        issue(0, 0, 1, 19'h000FF, 8'h00);
        // raw reads of the paging registers keep the cache
        push(1, 0, 1, 8'h47, 8'h00); exp_rsp.push_back(8'hA5);
        issue(1, 0, 1, 19'h22347, 8'h00);
        drain();
        bif.bus_data_i = 8'h77;
        push(0, 1, 0, 8'hFE, 8'h00); exp_rsp.push_back(8'h00);
        issue(0, 0, 0, 19'h000FE, 8'h00);
        push(0, 1, 0, 8'hFF, 8'hCA); push(0, 1, 0, 8'hFE, 8'h23); push(1, 0, 1, 8'h46, 8'h00);
        exp_rsp.push_back(8'h77);
        issue(1, 0, 1, 19'h22346, 8'h00);
        drain();
        // abort a write with reset partway through its cycle
        push(1, 0, 0, 8'h33, 8'h44);
        issue(0, 1, 0, 19'h00033, 8'h44);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk50);
            #1;
            if (active && tick == 30) break;
        end
        chk("abort_reach_ph30", {active, tick[7:0]}, {1'b1, 8'd30});
        rst = 1'b1;
        @(negedge clk50);
        #1;
        chk("abort_clke", bif.clke, 0);
        chk("abort_sel", {bif.pgfc_n, bif.pgfd_n}, 2'b11);
        chk("abort_oe", bif.bus_data_oe, 0);
        chk("abort_rsp", bif.rsp_valid, 0);
        chk("abort_ready", bif.cmd_ready, 0);
        rst = 1'b0;
        push(0, 1, 0, 8'hFF, 8'hCA); push(0, 1, 0, 8'hFE, 8'h23); push(1, 0, 0, 8'h46, 8'h11);
        exp_rsp.push_back(8'h00);
        issue(1, 0, 0, 19'h22346, 8'h11);
        drain();
        repeat (120) @(negedge clk50);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
